// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue/settle/capture sequencer around the 16-bit ALU
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opc,
    input  logic [15:0]              cmd_n,
    input  logic [15:0]              cmd_m,
    input  logic                     cmd_c,
    output logic [2:0]               alu_opc,
    output logic [15:0]              alu_n,
    output logic [15:0]              alu_m,
    output logic                     alu_c,
    input  logic [15:0]              alu_f,
    input  logic                     alu_zer,
    input  logic                     alu_neg,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_f,
    output logic                     res_zer,
    output logic                     res_neg,
    output logic [2:0]               res_opc,
    output logic [7:0]               res_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int             AW          = $clog2(DEPTH);
    localparam int             EW          = 3 + 16 + 16 + 1 + 8;
    localparam logic [AW:0]    FULL        = (AW+1)'(DEPTH);
    localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [EW-1:0] head;
    logic [1:0]    state;
    logic [3:0]    settle_cnt;
    logic [7:0]    tag_ctr;
    logic [7:0]    alu_tag;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;

    assign fifo_nonempty = (count != '0);
    assign cmd_ready     = (count < FULL) && !rst;
    assign push          = cmd_valid && cmd_ready;
    assign head          = mem[rptr];
    assign busy          = (state != IDLE) || fifo_nonempty;

    // Pops happen only from IDLE or when the held result is being consumed;
    // a command pushed this cycle is never visible to the pop (no bypass).
    assign pop = fifo_nonempty && ((state == IDLE) || ((state == HOLD) && res_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {cmd_opc, cmd_n, cmd_m, cmd_c, tag_ctr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            tag_ctr <= '0;
        end else begin
            if (push) begin
                wptr    <= wptr + AW'(1);
                tag_ctr <= tag_ctr + 8'd1;
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            alu_opc    <= '0;
            alu_n      <= '0;
            alu_m      <= '0;
            alu_c      <= 1'b0;
            alu_tag    <= '0;
            res_valid  <= 1'b0;
            res_f      <= '0;
            res_zer    <= 1'b0;
            res_neg    <= 1'b0;
            res_opc    <= '0;
            res_tag    <= '0;
        end else begin
            // The issue register is the only source of alu_*, so they hold between pops
            if (pop) begin
                {alu_opc, alu_n, alu_m, alu_c, alu_tag} <= head;
                settle_cnt <= SETTLE_LOAD;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        res_f     <= alu_f;
                        res_zer   <= alu_zer;
                        res_neg   <= alu_neg;
                        res_opc   <= alu_opc;
                        res_tag   <= alu_tag;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= pop ? DRIVE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer wrapped around the 16-bit ALU (`alu_structural`). It accepts ALU commands (opcode, two signed operands, carry-in) over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the ALU and holds its inputs stable for a fixed settle window. It then captures the ALU result and flags into an output register, presented downstream with a valid/ready handshake and a sequence tag.

## Interface

Parameters:
- DEPTH, 4, command FIFO depth; power of two, 2 to 16.
- SETTLE, 1, cycles the ALU inputs are held before the result is captured; 1 to 15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_opc  in  3  ALU opcode; opaque to this block.
- cmd_n  in  16  signed operand n.
- cmd_m  in  16  signed operand m.
- cmd_c  in  1  carry-in.
- alu_opc  out  3  drives ALU opc.
- alu_n  out  16  drives ALU n.
- alu_m  out  16  drives ALU m.
- alu_c  out  1  drives ALU c.
- alu_f  in  16  ALU result.
- alu_zer  in  1  ALU zero flag.
- alu_neg  in  1  ALU negative flag.
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  downstream accepts the result.
- res_f  out  16  captured result.
- res_zer  out  1  captured zero flag.
- res_neg  out  1  captured negative flag.
- res_opc  out  3  opcode that produced the result.
- res_tag  out  8  sequence number of the command.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  high when state != IDLE or count != 0.

## Operation

- Push: on `cmd_valid && cmd_ready` the block writes {opc, n, m, c, tag} into the FIFO. `tag` is an internal 8-bit counter that increments per accepted command and wraps from 255 to 0.
- `cmd_ready = (count < DEPTH) && !rst`. There is no bypass: every command passes through the FIFO.
- FSM states:
  - IDLE: if count != 0, pop the head into the issue register, load the settle counter with SETTLE-1, go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: the issue register drives `alu_*`. At the end of the cycle where the settle counter equals 0, capture {alu_f, alu_zer, alu_neg} plus the issued opc and tag into the result register, set res_valid, go to HOLD. Otherwise decrement the counter.
  - HOLD: res_valid is high and `alu_*` is unchanged. On `res_ready`:
    - clear res_valid;
    - if count != 0, pop the next command and go to DRIVE (reload the counter);
    - else go to IDLE.
- `alu_*` retain their last issued values in IDLE and HOLD; they change only on a pop.
- Simultaneous push and pop in the same cycle: the block performs both and count is unchanged.
- With count == DEPTH, cmd_ready is low. A pop in that cycle raises cmd_ready the following cycle.
- Results emerge in acceptance order, and tags are strictly consecutive mod 256.
- Captured values are the raw ALU outputs; this block does no width extension and no arithmetic.

## Timing

- Reset (asynchronous, immediate) sets:
  - state IDLE, count 0, tag counter 0;
  - all `alu_*` = 0;
  - res_valid 0, res_f 0, res_zer 0, res_neg 0, res_opc 0, res_tag 0;
  - busy 0, cmd_ready 0 while rst is high.
- Reset mid-operation discards FIFO contents, the in-flight command and any unconsumed result. The first command accepted after reset gets tag 0.
- Latency, with an empty FIFO in IDLE and acceptance at edge T:
  - pop at T+1, so `alu_*` are valid from T+1;
  - capture at T+SETTLE+1;
  - res_valid high from T+SETTLE+1, which is 2 edges after acceptance for SETTLE=1.
- Back-to-back throughput with res_ready held high: one result every SETTLE+1 cycles.
- res_f, res_zer, res_neg, res_opc and res_tag are stable while res_valid is high and res_ready is low.
- count updates at the edge following the push or pop.

## Test plan

The bench uses an ALU model with f = n + m + c, zer = (f == 0), neg = f[15].

- Reset then single command n=8, m=3, c=0, opc=0 -> alu_n=8 one cycle after acceptance; res_valid rises SETTLE+1 edges after acceptance with res_f=11, zer=0, neg=0, tag=0.
- Flag cases: (n=-5, m=5, c=0) -> res_f=0, zer=1, neg=0. Then (n=-8, m=3, c=0) -> res_f=-5 (16'hFFFB), zer=0, neg=1. Tags are 0 and 1.
- Backpressure: hold res_ready=0 and push 5 commands with DEPTH=4 -> 1 is in the issue/result path and 4 fill the FIFO, count=4, cmd_ready=0. A 6th push is not accepted. The first result stays stable. Release res_ready -> 5 results in order with tags 0..4.
- Simultaneous push/pop at count=2 -> count stays 2 and ordering is preserved.
- Tag wrap: 257 commands -> the 256th result carries tag 255 and the 257th carries tag 0.
- Assert rst while in DRIVE with count=3 -> res_valid=0, count=0, alu_* = 0 immediately. The next command gets tag 0.
